// File: rtl/fwd_hazard_if.sv
// Bundle between the ID/EX datapath and the forwarding/hazard unit.
// Optional FWD_STATS_EN adds the StallCount/FwdCount counter outputs.
interface fwd_hazard_if #(
  parameter int REG_ADDR_W = 5,
  parameter int FSEL_W     = 2
);
  logic                  ID_Valid;
  logic [REG_ADDR_W-1:0] ID_rs;
  logic [REG_ADDR_W-1:0] ID_rt;
  logic                  ID_UseRs;
  logic                  ID_UseRt;
  logic [REG_ADDR_W-1:0] ID_WriteReg;
  logic                  ID_RegWre;
  logic                  ID_MemRead;
  logic                  Flush;
  logic                  Stall;
  logic [FSEL_W-1:0]     ForwardA;
  logic [FSEL_W-1:0]     ForwardB;
`ifdef FWD_STATS_EN
  logic [31:0]           StallCount;
  logic [31:0]           FwdCount;

  modport master (
    output ID_Valid, ID_rs, ID_rt, ID_UseRs, ID_UseRt,
           ID_WriteReg, ID_RegWre, ID_MemRead, Flush,
    input  Stall, ForwardA, ForwardB, StallCount, FwdCount
  );
  modport slave (
    input  ID_Valid, ID_rs, ID_rt, ID_UseRs, ID_UseRt,
           ID_WriteReg, ID_RegWre, ID_MemRead, Flush,
    output Stall, ForwardA, ForwardB, StallCount, FwdCount
  );
`else
  modport master (
    output ID_Valid, ID_rs, ID_rt, ID_UseRs, ID_UseRt,
           ID_WriteReg, ID_RegWre, ID_MemRead, Flush,
    input  Stall, ForwardA, ForwardB
  );
  modport slave (
    input  ID_Valid, ID_rs, ID_rt, ID_UseRs, ID_UseRt,
           ID_WriteReg, ID_RegWre, ID_MemRead, Flush,
    output Stall, ForwardA, ForwardB
  );
`endif
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit with its own shadow pipeline of
// in-flight register writes (slot 0 = EX, slot k = k stages past EX).
// Optional macro FWD_STATS_EN adds 32-bit stall/forward event counters.
module fwd_hazard_unit #(
  parameter int REG_ADDR_W       = 5,
  parameter int FWD_DEPTH        = 2,
  parameter int LOAD_READY_STAGE = 2,
  parameter int FSEL_W           = $clog2(FWD_DEPTH + 1)
) (
  input  logic        CLK,
  input  logic        Reset,
  fwd_hazard_if.slave hz
);

  // Slot 0 additionally keeps the EX instruction's sources and use flags.
  logic [REG_ADDR_W-1:0] ex_rs_reg;
  logic [REG_ADDR_W-1:0] ex_rt_reg;
  logic                  ex_use_rs_reg;
  logic                  ex_use_rt_reg;

  logic [REG_ADDR_W-1:0] dst_reg [0:FWD_DEPTH];
  logic [FWD_DEPTH:0]    wre_reg;
  logic [FWD_DEPTH:0]    mrd_reg;
  logic [FWD_DEPTH:0]    slot_wr;

  logic                  stall;
  logic                  take_id;
  logic [FSEL_W-1:0]     fwd_a;
  logic [FSEL_W-1:0]     fwd_b;

  // A slot only produces a value when it writes a non-zero register.
  generate
    for (genvar gi = 0; gi <= FWD_DEPTH; gi++) begin : g_slot_wr
      assign slot_wr[gi] = wre_reg[gi] && (dst_reg[gi] != '0);
    end
  endgenerate

  assign take_id = hz.ID_Valid && !stall && !hz.Flush;

  // Shadow pipeline: slots keep moving during a stall, a bubble enters EX.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      ex_rs_reg     <= '0;
      ex_rt_reg     <= '0;
      ex_use_rs_reg <= 1'b0;
      ex_use_rt_reg <= 1'b0;
      for (int k = 0; k <= FWD_DEPTH; k++) begin
        dst_reg[k] <= '0;
      end
      wre_reg <= '0;
      mrd_reg <= '0;
    end else begin
      for (int k = 1; k <= FWD_DEPTH; k++) begin
        dst_reg[k] <= dst_reg[k-1];
        wre_reg[k] <= wre_reg[k-1];
        mrd_reg[k] <= mrd_reg[k-1];
      end
      if (take_id) begin
        ex_rs_reg     <= hz.ID_rs;
        ex_rt_reg     <= hz.ID_rt;
        ex_use_rs_reg <= hz.ID_UseRs;
        ex_use_rt_reg <= hz.ID_UseRt;
        dst_reg[0]    <= hz.ID_WriteReg;
        wre_reg[0]    <= hz.ID_RegWre;
        mrd_reg[0]    <= hz.ID_MemRead;
      end else begin
        ex_rs_reg     <= '0;
        ex_rt_reg     <= '0;
        ex_use_rs_reg <= 1'b0;
        ex_use_rt_reg <= 1'b0;
        dst_reg[0]    <= '0;
        wre_reg[0]    <= 1'b0;
        mrd_reg[0]    <= 1'b0;
      end
    end
  end

  // Bypass selects: scan oldest to youngest so the youngest producer wins.
  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      if (ex_use_rs_reg && (ex_rs_reg != '0) && slot_wr[k] && (dst_reg[k] == ex_rs_reg))
        fwd_a = FSEL_W'(k);
      if (ex_use_rt_reg && (ex_rt_reg != '0) && slot_wr[k] && (dst_reg[k] == ex_rt_reg))
        fwd_b = FSEL_W'(k);
    end
  end

  // Load-use stall while a matching load is younger than the ready slot;
  // flush and reset both drop it in the same cycle.
  always_comb begin
    stall = 1'b0;
    for (int j = 0; j < LOAD_READY_STAGE - 1; j++) begin
      if (slot_wr[j] && mrd_reg[j] &&
          ((hz.ID_UseRs && (dst_reg[j] == hz.ID_rs)) ||
           (hz.ID_UseRt && (dst_reg[j] == hz.ID_rt))))
        stall = 1'b1;
    end
    stall = stall && hz.ID_Valid && !hz.Flush && !Reset;
  end

  assign hz.Stall    = stall;
  assign hz.ForwardA = fwd_a;
  assign hz.ForwardB = fwd_b;

`ifdef FWD_STATS_EN
  logic [31:0] stall_cnt_reg;
  logic [31:0] fwd_cnt_reg;

  // Event counters, wrapping naturally at 2^32.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      stall_cnt_reg <= '0;
      fwd_cnt_reg   <= '0;
    end else begin
      if (stall)
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      if ((fwd_a != '0) || (fwd_b != '0))
        fwd_cnt_reg <= fwd_cnt_reg + 32'd1;
    end
  end

  assign hz.StallCount = stall_cnt_reg;
  assign hz.FwdCount   = fwd_cnt_reg;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: unit A uses the default geometry,
// unit B uses FWD_DEPTH=3 / LOAD_READY_STAGE=3. Define FWD_STATS_EN to
// also exercise the counters.
module tb_fwd_hazard_unit;

  logic CLK = 1'b0;
  logic Reset = 1'b1;
  always #5 CLK = ~CLK;

  fwd_hazard_if #(.REG_ADDR_W(5), .FSEL_W(2)) ifa ();
  fwd_hazard_if #(.REG_ADDR_W(5), .FSEL_W(2)) ifb ();

  fwd_hazard_unit #(.REG_ADDR_W(5), .FWD_DEPTH(2), .LOAD_READY_STAGE(2), .FSEL_W(2))
    ua (.CLK(CLK), .Reset(Reset), .hz(ifa));
  fwd_hazard_unit #(.REG_ADDR_W(5), .FWD_DEPTH(3), .LOAD_READY_STAGE(3), .FSEL_W(2))
    ub (.CLK(CLK), .Reset(Reset), .hz(ifb));

  typedef struct {
    bit          chk;
    bit          s;
    bit [1:0]    fa;
    bit [1:0]    fb;
    bit          cs;
    int unsigned sc;
    int unsigned fc;
    string       nm;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int n_chk  = 0;
  int n_fail = 0;

  bit          pend_cs = 1'b0;
  int unsigned pend_sc = 0;
  int unsigned pend_fc = 0;

  task automatic cmp(input string nm, input string what, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s %s actual=%0d required=%0d", nm, what, act, req);
    end
  endtask

  task automatic drv(input int sel, input bit v, input bit [4:0] rs, input bit urs,
                     input bit [4:0] rt, input bit urt, input bit [4:0] wr,
                     input bit wre, input bit mr, input bit fl);
    if (sel == 0) begin
      ifa.ID_Valid = v; ifa.ID_rs = rs; ifa.ID_UseRs = urs; ifa.ID_rt = rt; ifa.ID_UseRt = urt;
      ifa.ID_WriteReg = wr; ifa.ID_RegWre = wre; ifa.ID_MemRead = mr; ifa.Flush = fl;
    end else begin
      ifb.ID_Valid = v; ifb.ID_rs = rs; ifb.ID_UseRs = urs; ifb.ID_rt = rt; ifb.ID_UseRt = urt;
      ifb.ID_WriteReg = wr; ifb.ID_RegWre = wre; ifb.ID_MemRead = mr; ifb.Flush = fl;
    end
  endtask

  // One ID cycle on unit sel (the other unit sees a nop) plus its expectation.
  task automatic issue(input int sel, input bit v, input bit [4:0] rs, input bit urs,
                       input bit [4:0] rt, input bit urt, input bit [4:0] wr,
                       input bit wre, input bit mr, input bit fl,
                       input bit es, input bit [1:0] efa, input bit [1:0] efb, input string nm);
    exp_t e;
    @(posedge CLK);
    #1;
    Reset = 1'b0;
    drv(sel, v, rs, urs, rt, urt, wr, wre, mr, fl);
    drv(1 - sel, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    e.chk = 1'b1; e.s = es; e.fa = efa; e.fb = efb; e.nm = nm;
    e.cs = pend_cs; e.sc = pend_sc; e.fc = pend_fc;
    pend_cs = 1'b0;
    if (sel == 0) qa.push_back(e);
    else          qb.push_back(e);
  endtask

  task automatic op(input int sel, input bit [4:0] rs, input bit urs, input bit [4:0] rt,
                    input bit urt, input bit [4:0] wr, input bit wre, input bit mr,
                    input bit es, input bit [1:0] efa, input bit [1:0] efb, input string nm);
    issue(sel, 1'b1, rs, urs, rt, urt, wr, wre, mr, 1'b0, es, efa, efb, nm);
  endtask

  task automatic nop(input int sel, input bit es, input bit [1:0] efa, input bit [1:0] efb, input string nm);
    issue(sel, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, es, efa, efb, nm);
  endtask

  task automatic rst_cycle();
    @(posedge CLK);
    #1;
    Reset = 1'b1;
  endtask

  task automatic expect_cnt(input int unsigned sc, input int unsigned fc);
    pend_cs = 1'b1; pend_sc = sc; pend_fc = fc;
  endtask

  // Monitor for unit A.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (qa.size() > 0) begin
        e = qa.pop_front();
        if (e.chk) begin
          $display("A %-16s stall=%0d fwdA=%0d fwdB=%0d", e.nm, ifa.Stall, ifa.ForwardA, ifa.ForwardB);
          cmp(e.nm, "Stall", 32'(ifa.Stall), 32'(e.s));
          cmp(e.nm, "ForwardA", 32'(ifa.ForwardA), 32'(e.fa));
          cmp(e.nm, "ForwardB", 32'(ifa.ForwardB), 32'(e.fb));
`ifdef FWD_STATS_EN
          if (e.cs) begin
            cmp(e.nm, "StallCount", ifa.StallCount, e.sc);
            cmp(e.nm, "FwdCount", ifa.FwdCount, e.fc);
          end
`endif
        end
      end
    end
  end

  // Monitor for unit B.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (qb.size() > 0) begin
        e = qb.pop_front();
        if (e.chk) begin
          $display("B %-16s stall=%0d fwdA=%0d fwdB=%0d", e.nm, ifb.Stall, ifb.ForwardA, ifb.ForwardB);
          cmp(e.nm, "Stall", 32'(ifb.Stall), 32'(e.s));
          cmp(e.nm, "ForwardA", 32'(ifb.ForwardA), 32'(e.fa));
          cmp(e.nm, "ForwardB", 32'(ifb.ForwardB), 32'(e.fb));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    drv(0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    drv(1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    Reset = 1'b1;
    repeat (2) @(posedge CLK);

    // Reset state.
`ifdef FWD_STATS_EN
    expect_cnt(0, 0);
`endif
    nop(0, 0, 0, 0, "rst_a");
    nop(1, 0, 0, 0, "rst_b");

    // add r3 ; sub r3 -> ForwardA=1.
    op(0, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0, "s1_add_r3");
    op(0, 3, 1, 4, 1, 6, 1, 0, 0, 0, 0, "s1_sub");
    nop(0, 0, 1, 0, "s1_fwdA1");
    nop(0, 0, 0, 0, "s1_drain");

    // add r3 ; nop ; or rt=r3 -> ForwardB=2, then youngest of two r5 writers.
    op(0, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0, "s2_add_r3");
    nop(0, 0, 0, 0, "s2_gap");
    op(0, 1, 1, 3, 1, 8, 1, 0, 0, 0, 0, "s2_or");
    nop(0, 0, 0, 2, "s2_fwdB2");
    op(0, 1, 1, 0, 0, 5, 1, 0, 0, 0, 0, "s2_w5a");
    op(0, 2, 1, 0, 0, 5, 1, 0, 0, 0, 0, "s2_w5b");
    op(0, 5, 1, 3, 1, 9, 1, 0, 0, 0, 0, "s2_rd5");
    nop(0, 0, 1, 0, "s2_youngest");
    nop(0, 0, 0, 0, "s2_drain");

    // lw r4 ; add r4 -> one stall cycle, then ForwardA=2.
    op(0, 1, 1, 0, 0, 4, 1, 1, 0, 0, 0, "s3_lw_r4");
    op(0, 4, 1, 2, 1, 10, 1, 0, 1, 0, 0, "s3_add_stall");
    op(0, 4, 1, 2, 1, 10, 1, 0, 0, 0, 0, "s3_add_held");
    nop(0, 0, 2, 0, "s3_fwdA2");
    nop(0, 0, 0, 0, "s3_drain");
    // rt=r4 but unused -> no stall, no forward.
    op(0, 1, 1, 0, 0, 4, 1, 1, 0, 0, 0, "s3_lw_r4b");
    op(0, 1, 1, 4, 0, 11, 1, 0, 0, 0, 0, "s3_rt_unused");
    nop(0, 0, 0, 0, "s3_no_fwd");
    // rt=r4 used -> stall, then ForwardB=2.
    op(0, 1, 1, 0, 0, 4, 1, 1, 0, 0, 0, "s3_lw_r4c");
    op(0, 1, 1, 4, 1, 12, 1, 0, 1, 0, 0, "s3_rt_stall");
    op(0, 1, 1, 4, 1, 12, 1, 0, 0, 0, 0, "s3_rt_held");
    nop(0, 0, 0, 2, "s3_fwdB2");
    nop(0, 0, 0, 0, "s3_drain2");

    // Register 0 never forwards and a load to r0 never stalls.
    op(0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, "z_w_r0");
    op(0, 0, 1, 0, 1, 13, 1, 0, 0, 0, 0, "z_rd_r0");
    nop(0, 0, 0, 0, "z_sel0");
    op(0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, "z_lw_r0");
    op(0, 0, 1, 0, 1, 14, 1, 0, 0, 0, 0, "z_no_stall_r0");
    nop(0, 0, 0, 0, "z_drain");

    // Reset during a load stall clears every slot.
    op(0, 1, 1, 0, 0, 4, 1, 1, 0, 0, 0, "r_lw_r4");
    op(0, 4, 1, 0, 0, 15, 1, 0, 1, 0, 0, "r_add_stall");
    rst_cycle();
    op(0, 4, 1, 0, 0, 15, 1, 0, 0, 0, 0, "r_after_reset");
    nop(0, 0, 0, 0, "r_slots_empty");
    nop(0, 0, 0, 0, "r_drain");

    // Unit B: two stall cycles, then ForwardA=3.
    op(1, 1, 1, 0, 0, 7, 1, 1, 0, 0, 0, "b_lw_r7");
    op(1, 7, 1, 0, 0, 12, 1, 0, 1, 0, 0, "b_stall1");
    op(1, 7, 1, 0, 0, 12, 1, 0, 1, 0, 0, "b_stall2");
    op(1, 7, 1, 0, 0, 12, 1, 0, 0, 0, 0, "b_release");
    nop(1, 0, 3, 0, "b_fwdA3");
    nop(1, 0, 0, 0, "b_drain");
    // Flush in the first stall cycle drops Stall and inserts a bubble.
    op(1, 1, 1, 0, 0, 7, 1, 1, 0, 0, 0, "b_lw_r7b");
    issue(1, 1'b1, 7, 1'b1, 0, 1'b0, 12, 1'b1, 1'b0, 1'b1, 0, 0, 0, "b_flush");
    nop(1, 0, 0, 0, "b_bubble");
    nop(1, 0, 0, 0, "b_drain2");

`ifdef FWD_STATS_EN
    // Two load-use stalls then a simple forward.
    rst_cycle();
    expect_cnt(0, 0);
    op(0, 1, 1, 0, 0, 4, 1, 1, 0, 0, 0, "st_lw1");
    op(0, 4, 1, 2, 1, 10, 1, 0, 1, 0, 0, "st_stall1");
    op(0, 4, 1, 2, 1, 10, 1, 0, 0, 0, 0, "st_held1");
    nop(0, 0, 2, 0, "st_fwd1");
    op(0, 1, 1, 0, 0, 4, 1, 1, 0, 0, 0, "st_lw2");
    op(0, 4, 1, 2, 1, 10, 1, 0, 1, 0, 0, "st_stall2");
    op(0, 4, 1, 2, 1, 10, 1, 0, 0, 0, 0, "st_held2");
    nop(0, 0, 2, 0, "st_fwd2");
    expect_cnt(2, 2);
    op(0, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0, "st_add_r3");
    op(0, 3, 1, 4, 1, 6, 1, 0, 0, 0, 0, "st_sub");
    nop(0, 0, 1, 0, "st_fwdA1");
    expect_cnt(2, 3);
    nop(0, 0, 0, 0, "st_end");
`endif

    @(negedge CLK);
    #1;
    cmp("drain", "queueA_left", qa.size(), 0);
    cmp("drain", "queueB_left", qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and hazard unit for the pipelined CPU.
- Tracks every in-flight register write itself in a shadow pipeline of FWD_DEPTH stages past EX, so the datapath does not have to supply per-stage WriteReg/RegWre.
- Produces the EX-stage operand bypass selects and the ID-stage load-use Stall, including multi-cycle stalls when load data arrives late (LOAD_READY_STAGE > 2).

Parameters:
- REG_ADDR_W, 5, register address width; register 0 is hard-wired zero.
- FWD_DEPTH, 2, number of tracked stages after EX (slot 1 = MEM, slot 2 = WB, ...); must be >= 1.
- LOAD_READY_STAGE, 2, first slot index at which load data can be forwarded; range 1..FWD_DEPTH.
- FSEL_W, clog2(FWD_DEPTH+1), width of the forward selects.

Ports:
- CLK  in  1  clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- ID_Valid  in  1  ID holds a real instruction.
- ID_rs  in  REG_ADDR_W  ID source A.
- ID_rt  in  REG_ADDR_W  ID source B.
- ID_UseRs  in  1  instruction reads rs.
- ID_UseRt  in  1  instruction reads rt.
- ID_WriteReg  in  REG_ADDR_W  ID destination.
- ID_RegWre  in  1  ID writes a register.
- ID_MemRead  in  1  ID is a load.
- Flush  in  1  branch/jump flush of the ID instruction.
- Stall  out  1  hold PC and IF/ID; insert bubble into EX.
- ForwardA  out  FSEL_W  EX operand A source: 0 = register file, k = slot k result.
- ForwardB  out  FSEL_W  EX operand B source, same encoding.

Behaviour:
- State: slot 0 holds the EX instruction {rs, rt, usage flags, dest, wre, memread}. Slots 1..FWD_DEPTH hold {dest, wre, memread}.
- A slot "writes" only if wre=1 and dest != 0.
- Each rising CLK edge:
  - slot[k] <= slot[k-1] for k = 1..FWD_DEPTH; the oldest entry falls off.
  - slot 0 <= ID fields if ID_Valid && !Stall && !Flush; otherwise a bubble (wre=0, memread=0, use flags=0).
  - Slots keep shifting during a stall; only ID is held.
- Forwarding (combinational from registered state):
  - For each EX source with its use flag set, search slots 1..FWD_DEPTH from the lowest index upward.
  - The first writing slot whose dest equals the source sets the select to that index k (youngest producer wins).
  - If no slot matches, the select is 0. Source register 0 always gives select 0.
- Load-use stall (combinational):
  - Stall=1 when ID_Valid && !Flush and, for some slot j in 0..LOAD_READY_STAGE-2, that slot writes, memread=1, and dest equals ID_rs (with ID_UseRs) or ID_rt (with ID_UseRt).
  - Stall re-evaluates every cycle, so the number of stall cycles equals the remaining distance to LOAD_READY_STAGE.
  - With LOAD_READY_STAGE=1, Stall is constant 0.
- Flush overrides Stall: Stall=0 and a bubble enters slot 0.
- Reset (synchronous): all slots cleared to bubbles; Stall=0, ForwardA=0, ForwardB=0 during the cycle after the reset edge. Reset mid-stall drops the stall immediately.
- Invariant: a select never points at a load slot with index < LOAD_READY_STAGE; the stall guarantees this.

Optional Feature:
- Macro FWD_STATS_EN.
- Defined:
  - Adds output StallCount (32-bit), +1 on each CLK edge where Stall=1, wrapping at 2^32-1 -> 0.
  - Adds output FwdCount (32-bit), +1 on each edge where ForwardA != 0 or ForwardB != 0 (counts 1 even when both are non-zero), same wrap rule.
  - Both counters cleared by Reset.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- Defaults. Issue add r3 (writes r3), then sub using r3 as rs -> next cycle ForwardA=1, ForwardB=0, Stall never asserted.
- Defaults. Issue add r3, then nop, then or using r3 as rt -> ForwardB=2 while the or is in EX. Next, write r5 in two consecutive instructions, then read r5 -> ForwardA=1 (youngest wins, not 2).
- Defaults. lw r4, then add reading r4 -> Stall=1 for exactly 1 cycle, a bubble enters EX, then ForwardA=2. Repeat with ID_UseRt=0 and ID_rt=4 -> no stall.
- LOAD_READY_STAGE=3, FWD_DEPTH=3. lw r7, then a dependent instruction -> Stall=1 for 2 cycles, then ForwardA=3. Assert Flush during the first stall cycle -> Stall drops to 0 that cycle and a bubble is inserted.
- Register 0 and reset. Write r0, then read r0 -> selects stay 0. Assert Reset for one cycle during a load stall -> cycle after the reset edge: Stall=0, ForwardA=ForwardB=0, all slots empty.
- FWD_STATS_EN defined. Run the load-use case twice -> StallCount=2. Run the first scenario -> FwdCount increments by 1.
